// File: rtl/ps2_pkg.sv
// Shared PS/2 decode constants, state encodings and the non-key byte filter.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   // start + 8 data + parity + stop, minus the start bit consumed in F_IDLE
   localparam int unsigned FRAME_BITS = 10;
   localparam int unsigned BIT_W      = 4;

   typedef enum logic [1:0] {F_IDLE, F_SHIFT, F_CHECK} frame_state_t;
   typedef enum logic [1:0] {D_IDLE, D_EXT, D_BRK, D_EXT_BRK} dec_state_t;

   // Keyboard status/response bytes that never name a key
   function automatic logic is_nonkey(input logic [7:0] code);
      case (code)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_nonkey = 1'b1;
         default:                                  is_nonkey = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 pin synchronizer, clock glitch filter and 11-bit frame receiver with timeout.
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN  = 8,
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       byte_valid_c,
   output logic [7:0] rx_byte,
   output logic       frame_err_c
);

   localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);
   localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC + 1);

   logic [1:0]              clk_sync_q, clk_sync_d;
   logic [1:0]              dat_sync_q, dat_sync_d;
   logic                    filt_q, filt_d;
   logic [FCNT_W-1:0]       fcnt_q, fcnt_d;
   frame_state_t            state_q, state_d;
   logic [BIT_W-1:0]        bitcnt_q, bitcnt_d;
   logic [FRAME_BITS-1:0]   shift_q, shift_d;
   logic [TO_W-1:0]         tmo_q, tmo_d;
   logic                    fall_c;
   logic                    data_bit_c;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
         filt_q     <= 1'b1;
         fcnt_q     <= '0;
         state_q    <= F_IDLE;
         bitcnt_q   <= '0;
         shift_q    <= '0;
         tmo_q      <= '0;
      end else begin
         clk_sync_q <= clk_sync_d;
         dat_sync_q <= dat_sync_d;
         filt_q     <= filt_d;
         fcnt_q     <= fcnt_d;
         state_q    <= state_d;
         bitcnt_q   <= bitcnt_d;
         shift_q    <= shift_d;
         tmo_q      <= tmo_d;
      end
   end

   // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it
   always_comb begin
      clk_sync_d = {clk_sync_q[0], ps2_clk};
      dat_sync_d = {dat_sync_q[0], ps2_data};
      filt_d     = filt_q;
      fcnt_d     = '0;
      if (clk_sync_q[1] != filt_q) begin
         if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) filt_d = ~filt_q;
         else                                   fcnt_d = fcnt_q + FCNT_W'(1);
      end
      fall_c     = filt_q & ~filt_d;
      data_bit_c = dat_sync_q[1];
   end

   // Frame FSM: bits land LSB first; shift_q ends as {stop, parity, data[7:0]}
   always_comb begin
      state_d      = state_q;
      bitcnt_d     = bitcnt_q;
      shift_d      = shift_q;
      tmo_d        = '0;
      byte_valid_c = 1'b0;
      frame_err_c  = 1'b0;
      case (state_q)
         F_IDLE: begin
            if (fall_c) begin
               if (!data_bit_c) begin
                  state_d  = F_SHIFT;
                  bitcnt_d = '0;
               end else begin
                  frame_err_c = 1'b1;
               end
            end
         end
         F_SHIFT: begin
            if (fall_c) begin
               shift_d = {data_bit_c, shift_q[FRAME_BITS-1:1]};
               if (bitcnt_q == BIT_W'(FRAME_BITS - 1)) state_d = F_CHECK;
               else                                    bitcnt_d = bitcnt_q + BIT_W'(1);
            end else if (tmo_q == TO_W'(TIMEOUT_CYC - 1)) begin
               frame_err_c = 1'b1;
               state_d     = F_IDLE;
            end else begin
               tmo_d = tmo_q + TO_W'(1);
            end
         end
         F_CHECK: begin
            if ((^shift_q[8:0]) && shift_q[9]) byte_valid_c = 1'b1;
            else                               frame_err_c  = 1'b1;
            state_d = F_IDLE;
         end
         default: state_d = F_IDLE;
      endcase
   end

   assign rx_byte = shift_q[7:0];

endmodule

// File: rtl/ps2_keycode_source.sv
// Turns received PS/2 bytes into a held keycode level plus press/release/error strobes.
module ps2_keycode_source
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN  = 8,
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] keycode,
   output logic       extended,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       frame_err
);

   logic        byte_valid_c;
   logic [7:0]  rx_byte;
   logic        rx_err_c;

   dec_state_t  dec_q, dec_d;
   logic [7:0]  keycode_q, keycode_d;
   logic        extended_q, extended_d;
   logic        press_q, press_d;
   logic        release_q, release_d;
   logic        frame_err_q, frame_err_d;
   logic        ext_bit_c;

   ps2_frame_rx #(
      .FILTER_LEN  (FILTER_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_frame_rx (
      .Clk          (Clk),
      .Reset        (Reset),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .byte_valid_c (byte_valid_c),
      .rx_byte      (rx_byte),
      .frame_err_c  (rx_err_c)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         dec_q       <= D_IDLE;
         keycode_q   <= '0;
         extended_q  <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         dec_q       <= dec_d;
         keycode_q   <= keycode_d;
         extended_q  <= extended_d;
         press_q     <= press_d;
         release_q   <= release_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Prefix tracking; a make of the already-held key (typematic) is silent
   always_comb begin
      dec_d       = dec_q;
      keycode_d   = keycode_q;
      extended_d  = extended_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      frame_err_d = rx_err_c;
      ext_bit_c   = 1'b0;
      if (byte_valid_c) begin
         if (is_nonkey(rx_byte)) begin
            dec_d = D_IDLE;
         end else if (rx_byte == PS2_EXT) begin
            dec_d = (dec_q == D_IDLE) ? D_EXT : D_IDLE;
         end else if (rx_byte == PS2_BRK) begin
            case (dec_q)
               D_IDLE:  dec_d = D_BRK;
               D_EXT:   dec_d = D_EXT_BRK;
               default: dec_d = D_IDLE;
            endcase
         end else begin
            case (dec_q)
               D_IDLE, D_EXT: begin
                  ext_bit_c = (dec_q == D_EXT);
                  if ({ext_bit_c, rx_byte} != {extended_q, keycode_q}) begin
                     keycode_d  = rx_byte;
                     extended_d = ext_bit_c;
                     press_d    = 1'b1;
                  end
               end
               default: begin
                  ext_bit_c = (dec_q == D_EXT_BRK);
                  release_d = 1'b1;
                  if ({ext_bit_c, rx_byte} == {extended_q, keycode_q}) begin
                     keycode_d  = '0;
                     extended_d = 1'b0;
                  end
               end
            endcase
            dec_d = D_IDLE;
         end
      end
   end

   assign keycode       = keycode_q;
   assign extended      = extended_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_ps2_keycode_source.sv
// Scoreboard bench: stimulus pushes expected strobes, a monitor pops them as the DUT fires.
module tb_ps2_keycode_source;

   localparam int unsigned FILT = 8;
   localparam int unsigned TMO  = 1000;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] keycode;
   logic       extended;
   logic       press_pulse;
   logic       release_pulse;
   logic       frame_err;

   typedef struct packed {
      logic       press;
      logic       rel;
      logic       err;
      logic       ext;
      logic [7:0] key;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   ps2_keycode_source #(
      .FILTER_LEN  (FILT),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .ps2_clk       (ps2_clk),
      .ps2_data      (ps2_data),
      .keycode       (keycode),
      .extended      (extended),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .frame_err     (frame_err)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic expect_ev(input logic p, input logic r, input logic e,
                            input logic x, input logic [7:0] k);
      ev_t ev;
      ev.press = p; ev.rel = r; ev.err = e; ev.ext = x; ev.key = k;
      exp_q.push_back(ev);
   endtask

   // Monitor: every strobe cycle must match the next queued expectation
   initial begin
      ev_t got;
      ev_t e;
      forever begin
         @(negedge Clk);
         if (!Reset && (press_pulse || release_pulse || frame_err)) begin
            got = '{press_pulse, release_pulse, frame_err, extended, keycode};
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: got %h expected none", got);
            end else begin
               e = exp_q.pop_front();
               check("event", 32'(got), 32'(e));
            end
         end
      end
   end

   task automatic ps2_bit(input logic b);
      @(negedge Clk);
      ps2_data = b;
      repeat (10) @(negedge Clk);
      ps2_clk = 1'b0;
      repeat (20) @(negedge Clk);
      ps2_clk = 1'b1;
      repeat (10) @(negedge Clk);
   endtask

   task automatic send_bits(input logic [7:0] d, input logic bad_par, input int nbits);
      logic [10:0] fr;
      fr = {1'b1, (bad_par ? ^d : ~^d), d, 1'b0};
      for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
      repeat (40) @(negedge Clk);
   endtask

   task automatic send_frame(input logic [7:0] d);
      send_bits(d, 1'b0, 11);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge Clk);
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_keycode"}, 32'(keycode), 32'h00);
      check({tag, "_extended"}, 32'(extended), 32'd0);
      check({tag, "_press"}, 32'(press_pulse), 32'd0);
      check({tag, "_release"}, 32'(release_pulse), 32'd0);
      check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
   endtask

   initial begin
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      Reset    = 1'b1;
      repeat (5) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      check_idle_outputs("reset");

      // W make, typematic repeat, then break
      expect_ev(1, 0, 0, 0, 8'h1D);
      send_frame(8'h1D);
      send_frame(8'h1D);
      expect_ev(0, 1, 0, 0, 8'h00);
      send_frame(8'hF0);
      send_frame(8'h1D);
      drain("w_sequence");

      // Extended up arrow, then non-extended break leaves it held
      expect_ev(1, 0, 0, 1, 8'h75);
      send_frame(8'hE0);
      send_frame(8'h75);
      expect_ev(0, 1, 0, 1, 8'h75);
      send_frame(8'hF0);
      send_frame(8'h75);
      drain("up_arrow");
      check("held_up_ext", 32'(extended), 32'd1);

      // Bad parity, then a good frame
      expect_ev(0, 0, 1, 1, 8'h75);
      send_bits(8'h1C, 1'b1, 11);
      expect_ev(1, 0, 0, 0, 8'h1C);
      send_frame(8'h1C);
      drain("parity");

      // Stalled frame times out, next frame accepted
      expect_ev(0, 0, 1, 0, 8'h1C);
      send_bits(8'h29, 1'b0, 5);
      repeat (TMO + 1) @(negedge Clk);
      expect_ev(1, 0, 0, 0, 8'h29);
      send_frame(8'h29);
      drain("timeout");

      // Lone fall with data high is a bad start bit
      expect_ev(0, 0, 1, 0, 8'h29);
      ps2_bit(1'b1);
      repeat (40) @(negedge Clk);
      drain("bad_start");

      // Reset in the middle of E0 F0 74
      send_frame(8'hE0);
      send_frame(8'hF0);
      send_bits(8'h74, 1'b0, 5);
      Reset = 1'b1;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      check_idle_outputs("mid_reset");
      expect_ev(1, 0, 0, 0, 8'h74);
      send_frame(8'h74);
      drain("after_reset");

      // F0 in D_BRK is dropped, so 29 is a make
      expect_ev(1, 0, 0, 0, 8'h29);
      send_frame(8'hF0);
      send_frame(8'hF0);
      send_frame(8'h29);
      // Extended break of a non-extended held key keeps it held
      expect_ev(0, 1, 0, 0, 8'h29);
      send_frame(8'hE0);
      send_frame(8'hF0);
      send_frame(8'h29);
      // Non-key byte cancels the E0 prefix: 29 is then a silent repeat
      send_frame(8'hE0);
      send_frame(8'hAA);
      send_frame(8'h29);
      repeat (100) @(negedge Clk);
      drain("prefix_cases");
      check("final_keycode", 32'(keycode), 32'h29);
      check("final_extended", 32'(extended), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
